// File: rtl/cv32e40p_x_pkg.sv
// Shared types for the core-side C-interface offload path.
// No logic; request/response bundles and the default in-flight depth.
package cv32e40p_x_pkg;

    localparam int unsigned X_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0]       instr;
        logic [2:0][31:0]  rs;
        logic [4:0]        rd;
    } x_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        error;
        logic        dualwb;
        logic [31:0] hart_id;
    } x_rsp_t;

endpackage

// File: rtl/cv32e40p_x_id_fifo.sv
// In-order queue of issued destination registers; head visible combinationally, push->head 1 cycle.
// No internal backpressure: caller gates push on full and pop on empty; push+pop legal when full.
module cv32e40p_x_id_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [4:0]                 push_dat_i,
    input  logic                       pop_i,
    output logic [4:0]                 head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/cv32e40p_x_offload_ctrl.sv
// Offload request register, rd hazard scoreboard, in-order response retire and writeback; accept->c_q 1 cycle, response->wb 1 cycle.
// Stalls ID on full/hazard/held request; stalls responses while the writeback register is occupied.
module cv32e40p_x_offload_ctrl
    import cv32e40p_x_pkg::*;
#(
    parameter int unsigned DEPTH   = X_DEPTH_DEFAULT,
    parameter logic [31:0] HART_ID = 32'd0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              off_valid_i,
    output logic              off_ready_o,
    input  logic [31:0]       off_instr_i,
    input  logic [2:0][31:0]  off_rs_i,
    input  logic [4:0]        off_rd_i,
    input  logic              flush_i,
    output logic              c_q_valid_o,
    input  logic              c_p_ready_i,
    output logic [4:0]        c_q_addr_o,
    output logic [2:0][31:0]  c_q_rs_o,
    output logic [31:0]       c_q_instr_data_o,
    output logic [31:0]       c_q_hart_id_o,
    input  logic              c_p_valid_i,
    output logic              c_q_ready_o,
    input  logic [31:0]       c_p_data_i,
    input  logic              c_p_error_i,
    input  logic              c_p_dualwb_i,
    input  logic [31:0]       c_p_hart_id_i,
    input  logic [4:0]        c_p_rd_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [4:0]        wb_rd_o,
    output logic [31:0]       wb_data_o,
    output logic [31:0]       pending_o,
    output logic              busy_o,
    output logic              err_o
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    x_req_t        req_q, req_d;
    logic          req_vld_q, req_vld_d;
    logic [31:0]   pending_q, pending_d;
    logic          wb_vld_q, wb_vld_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          err_q, err_d;

    logic [4:0]    head_rd;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty;
    x_rsp_t        rsp;
    logic          acc, iss, ret, drop, rsp_err, slot_ok;

    assign rsp = '{data: c_p_data_i, rd: c_p_rd_i, error: c_p_error_i,
                   dualwb: c_p_dualwb_i, hart_id: c_p_hart_id_i};

    // The held request will need a fifo slot once issued, so it is counted against DEPTH.
    assign slot_ok     = !fifo_full && !(req_vld_q && (count == CW'(DEPTH - 1)));
    assign off_ready_o = (!req_vld_q || c_p_ready_i) && slot_ok && !pending_q[off_rd_i];
    assign acc         = off_valid_i && off_ready_o;
    assign iss         = req_vld_q && c_p_ready_i;
    assign drop        = flush_i && req_vld_q && !c_p_ready_i;

    assign c_q_ready_o = (!wb_vld_q || wb_ready_i) && !fifo_empty;
    assign ret         = c_p_valid_i && c_q_ready_o;
    assign rsp_err     = (rsp.rd != head_rd) || (rsp.hart_id != HART_ID) || rsp.error || rsp.dualwb;

    always_comb begin
        req_d     = req_q;
        req_vld_d = req_vld_q;
        if (acc) begin
            req_d     = '{instr: off_instr_i, rs: off_rs_i, rd: off_rd_i};
            req_vld_d = 1'b1;
        end else if (iss || drop) begin
            req_vld_d = 1'b0;
        end
    end

    // Clears first so a same-cycle set of the same rd wins.
    always_comb begin
        pending_d = pending_q;
        if (ret) pending_d[head_rd] = 1'b0;
        if (drop) pending_d[req_q.rd] = 1'b0;
        if (acc) pending_d[off_rd_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        wb_vld_d  = wb_vld_q && !wb_ready_i;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (ret && !rsp_err && (head_rd != 5'd0)) begin
            wb_vld_d  = 1'b1;
            wb_rd_d   = head_rd;
            wb_data_d = rsp.data;
        end
    end

    assign err_d = ret && rsp_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q     <= '0;
            req_vld_q <= 1'b0;
            pending_q <= '0;
            wb_vld_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            req_q     <= req_d;
            req_vld_q <= req_vld_d;
            pending_q <= pending_d;
            wb_vld_q  <= wb_vld_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    cv32e40p_x_id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (iss),
        .push_dat_i (req_q.rd),
        .pop_i      (ret),
        .head_o     (head_rd),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (count)
    );

    assign c_q_valid_o      = req_vld_q;
    assign c_q_addr_o       = req_q.rd;
    assign c_q_rs_o         = req_q.rs;
    assign c_q_instr_data_o = req_q.instr;
    assign c_q_hart_id_o    = HART_ID;
    assign wb_valid_o       = wb_vld_q;
    assign wb_rd_o          = wb_rd_q;
    assign wb_data_o        = wb_data_q;
    assign pending_o        = pending_q;
    assign busy_o           = req_vld_q || !fifo_empty;
    assign err_o            = err_q;

endmodule

// File: tb/tb_cv32e40p_x_offload_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_cv32e40p_x_offload_ctrl;
    localparam int          DEPTH = 4;
    localparam logic [31:0] HART  = 32'h0000_0003;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              off_valid_i, off_ready_o;
    logic [31:0]       off_instr_i;
    logic [2:0][31:0]  off_rs_i;
    logic [4:0]        off_rd_i;
    logic              flush_i;
    logic              c_q_valid_o, c_p_ready_i;
    logic [4:0]        c_q_addr_o;
    logic [2:0][31:0]  c_q_rs_o;
    logic [31:0]       c_q_instr_data_o, c_q_hart_id_o;
    logic              c_p_valid_i, c_q_ready_o;
    logic [31:0]       c_p_data_i;
    logic              c_p_error_i, c_p_dualwb_i;
    logic [31:0]       c_p_hart_id_i;
    logic [4:0]        c_p_rd_i;
    logic              wb_valid_o, wb_ready_i;
    logic [4:0]        wb_rd_o;
    logic [31:0]       wb_data_o, pending_o;
    logic              busy_o, err_o;

    cv32e40p_x_offload_ctrl #(.DEPTH(DEPTH), .HART_ID(HART)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .off_valid_i(off_valid_i), .off_ready_o(off_ready_o), .off_instr_i(off_instr_i),
        .off_rs_i(off_rs_i), .off_rd_i(off_rd_i), .flush_i(flush_i),
        .c_q_valid_o(c_q_valid_o), .c_p_ready_i(c_p_ready_i), .c_q_addr_o(c_q_addr_o),
        .c_q_rs_o(c_q_rs_o), .c_q_instr_data_o(c_q_instr_data_o), .c_q_hart_id_o(c_q_hart_id_o),
        .c_p_valid_i(c_p_valid_i), .c_q_ready_o(c_q_ready_o), .c_p_data_i(c_p_data_i),
        .c_p_error_i(c_p_error_i), .c_p_dualwb_i(c_p_dualwb_i), .c_p_hart_id_i(c_p_hart_id_i),
        .c_p_rd_i(c_p_rd_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .pending_o(pending_o),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference state: one optional held request, an ordered list of issued rds,
    // an optional pending writeback and the error pulse.
    bit          m_vld;
    int          m_rd;
    logic [31:0] m_instr;
    logic [95:0] m_rs;
    int          mq[$];
    bit          m_wb_vld;
    int          m_wb_rd;
    logic [31:0] m_wb_data;
    bit          m_err;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit pend(input int n);
        if (n == 0) return 1'b0;
        if (m_vld && m_rd == n) return 1'b1;
        foreach (mq[i]) if (mq[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mreset();
        m_vld = 0; m_rd = 0; m_instr = '0; m_rs = '0;
        mq.delete();
        m_wb_vld = 0; m_wb_rd = 0; m_wb_data = '0; m_err = 0;
    endtask

    task automatic idle();
        off_valid_i = 0; off_instr_i = '0; off_rs_i = '0; off_rd_i = '0; flush_i = 0;
        c_p_ready_i = 1; c_p_valid_i = 0; c_p_data_i = '0; c_p_error_i = 0;
        c_p_dualwb_i = 0; c_p_hart_id_i = HART; c_p_rd_i = '0; wb_ready_i = 1;
    endtask

    task automatic check_reset();
        chk("rst_cq_valid", c_q_valid_o, 0);
        chk("rst_cq_addr", c_q_addr_o, 0);
        chk("rst_cq_instr", c_q_instr_data_o, 0);
        chk("rst_cq_rs", c_q_rs_o, 0);
        chk("rst_cq_hart", c_q_hart_id_o, HART);
        chk("rst_c_q_ready", c_q_ready_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_rd", wb_rd_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
    endtask

    // Called just after a falling edge with inputs driven; compares, advances the model
    // over the next rising edge, and returns at the following falling edge.
    task automatic cycle();
        bit e_ordy, e_crdy, acc, iss, ret, drop, bad;
        int head;
        logic [31:0] e_pend;
        #1;
        for (int n = 0; n < 32; n++) e_pend[n] = pend(n);
        e_ordy = (!m_vld || c_p_ready_i) && (mq.size() + (m_vld ? 1 : 0) < DEPTH)
                 && !pend(int'(off_rd_i));
        e_crdy = (!m_wb_vld || wb_ready_i) && (mq.size() != 0);
        chk("off_ready", off_ready_o, e_ordy);
        chk("c_q_ready", c_q_ready_o, e_crdy);
        chk("c_q_valid", c_q_valid_o, m_vld);
        if (m_vld) begin
            chk("c_q_addr", c_q_addr_o, m_rd);
            chk("c_q_instr", c_q_instr_data_o, m_instr);
            chk("c_q_rs", c_q_rs_o, m_rs);
        end
        chk("c_q_hart", c_q_hart_id_o, HART);
        chk("wb_valid", wb_valid_o, m_wb_vld);
        if (m_wb_vld) begin
            chk("wb_rd", wb_rd_o, m_wb_rd);
            chk("wb_data", wb_data_o, m_wb_data);
        end
        chk("pending", pending_o, e_pend);
        chk("busy", busy_o, m_vld || mq.size() != 0);
        chk("err", err_o, m_err);

        acc  = off_valid_i && e_ordy;
        iss  = m_vld && c_p_ready_i;
        ret  = c_p_valid_i && e_crdy;
        drop = flush_i && m_vld && !c_p_ready_i;
        m_err = 0;
        m_wb_vld = m_wb_vld && !wb_ready_i;
        if (ret) begin
            head = mq.pop_front();
            bad = (int'(c_p_rd_i) != head) || (c_p_hart_id_i != HART) || c_p_error_i || c_p_dualwb_i;
            m_err = bad;
            if (!bad && head != 0) begin
                m_wb_vld = 1; m_wb_rd = head; m_wb_data = c_p_data_i;
            end
        end
        if (iss) mq.push_back(m_rd);
        if (acc) begin
            m_vld = 1; m_rd = int'(off_rd_i); m_instr = off_instr_i; m_rs = off_rs_i;
        end else if (iss || drop) begin
            m_vld = 0;
        end
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic one_op(input int rd);
        off_valid_i = 1; off_rd_i = 5'(rd); off_instr_i = $urandom;
        cycle();
        off_valid_i = 0;
        cycle();
    endtask

    initial begin
        idle();
        rst_ni = 0;
        mreset();
        #1;
        check_reset();
        @(negedge clk_i);
        rst_ni = 1;

        // Single op
        off_valid_i = 1; off_rd_i = 5; off_instr_i = 32'h0000_0053;
        off_rs_i = {32'h3, 32'h2, 32'h1};
        cycle();
        chk("t1_cq_valid", c_q_valid_o, 1);
        chk("t1_cq_addr", c_q_addr_o, 5);
        chk("t1_pend5_acc", pending_o[5], 1);
        off_valid_i = 0;
        cycle();
        chk("t1_pend5_inflight", pending_o[5], 1);
        c_p_valid_i = 1; c_p_rd_i = 5; c_p_data_i = 32'h3F80_0000;
        cycle();
        chk("t1_wb_valid", wb_valid_o, 1);
        chk("t1_wb_rd", wb_rd_o, 5);
        chk("t1_wb_data", wb_data_o, 32'h3F80_0000);
        chk("t1_pend_clear", pending_o, 0);
        idle();
        cycle();
        chk("t1_wb_drained", wb_valid_o, 0);

        // Backpressure on the request channel
        c_p_ready_i = 0; off_valid_i = 1; off_rd_i = 6; off_instr_i = 32'h1234_5678;
        cycle();
        off_rd_i = 8; off_instr_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_ordy_stall", off_ready_o, 0);
            chk("t2_addr_hold", c_q_addr_o, 6);
            chk("t2_instr_hold", c_q_instr_data_o, 32'h1234_5678);
            cycle();
        end
        c_p_ready_i = 1; off_valid_i = 0;
        cycle();
        chk("t2_one_issue", c_q_valid_o, 0);
        c_p_valid_i = 1; c_p_rd_i = 6;
        cycle();
        idle();
        cycle();
        chk("t2_drained", busy_o, 0);

        // Fill to DEPTH
        off_valid_i = 1;
        for (int i = 1; i <= 4; i++) begin
            off_rd_i = 5'(i);
            cycle();
        end
        off_rd_i = 10;
        #1;
        chk("t3_fifth_ordy", off_ready_o, 0);
        cycle();
        off_valid_i = 0;
        #1;
        chk("t3_full_ordy", off_ready_o, 0);
        for (int i = 1; i <= 4; i++) begin
            c_p_valid_i = 1; c_p_rd_i = 5'(i); c_p_data_i = 32'h100 + 32'(i);
            cycle();
            chk("t3_wb_valid", wb_valid_o, 1);
            chk("t3_wb_order", wb_rd_o, i);
        end
        idle();
        cycle();
        chk("t3_empty_busy", busy_o, 0);
        chk("t3_empty_crdy", c_q_ready_o, 0);

        // rd hazard and rd=0
        off_valid_i = 1; off_rd_i = 7;
        cycle();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("t4_stall", off_ready_o, 0);
            cycle();
        end
        c_p_valid_i = 1; c_p_rd_i = 7;
        #1;
        chk("t4_stall_ret", off_ready_o, 0);
        cycle();
        c_p_valid_i = 0;
        #1;
        chk("t4_release", off_ready_o, 1);
        cycle();
        off_valid_i = 0;
        cycle();
        c_p_valid_i = 1; c_p_rd_i = 7;
        cycle();
        idle();
        cycle();
        one_op(0);
        chk("t4_rd0_pend", pending_o, 0);
        c_p_valid_i = 1; c_p_rd_i = 0; c_p_data_i = 32'hCAFE;
        cycle();
        chk("t4_rd0_nowb", wb_valid_o, 0);
        chk("t4_rd0_noerr", err_o, 0);
        idle();
        cycle();

        // Error retirements
        for (int k = 0; k < 4; k++) begin
            one_op(3);
            c_p_valid_i = 1; c_p_rd_i = (k == 0) ? 5'd9 : 5'd3;
            c_p_dualwb_i = (k == 1); c_p_error_i = (k == 2);
            c_p_hart_id_i = (k == 3) ? 32'h7 : HART;
            cycle();
            chk("t5_err_pulse", err_o, 1);
            chk("t5_no_wb", wb_valid_o, 0);
            chk("t5_retired", busy_o, 0);
            idle();
            cycle();
            chk("t5_err_once", err_o, 0);
        end

        // Flush and mid-flight reset
        c_p_ready_i = 0; off_valid_i = 1; off_rd_i = 12;
        cycle();
        chk("t6_pend12", pending_o[12], 1);
        off_valid_i = 0; flush_i = 1;
        cycle();
        chk("t6_dropped", c_q_valid_o, 0);
        chk("t6_pend_clr", pending_o, 0);
        idle();
        off_valid_i = 1; off_rd_i = 13;
        cycle();
        off_rd_i = 14;
        cycle();
        off_valid_i = 0;
        cycle();
        chk("t6_two_inflight", pending_o, (32'd1 << 13) | (32'd1 << 14));
        rst_ni = 0;
        #1;
        check_reset();
        mreset();
        @(posedge clk_i);
        #1;
        chk("t6_rst_busy_edge", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            off_valid_i   = $urandom_range(0, 1) == 1;
            off_rd_i      = 5'($urandom_range(0, 7));
            off_instr_i   = $urandom;
            off_rs_i      = {$urandom, $urandom, $urandom};
            flush_i       = $urandom_range(0, 9) == 0;
            c_p_ready_i   = $urandom_range(0, 9) < 6;
            c_p_valid_i   = $urandom_range(0, 1) == 1;
            c_p_rd_i      = (mq.size() > 0 && $urandom_range(0, 9) != 0) ? 5'(mq[0])
                                                                       : 5'($urandom_range(0, 31));
            c_p_hart_id_i = ($urandom_range(0, 19) == 0) ? ~HART : HART;
            c_p_error_i   = $urandom_range(0, 19) == 0;
            c_p_dualwb_i  = $urandom_range(0, 19) == 0;
            c_p_data_i    = $urandom;
            wb_ready_i    = $urandom_range(0, 9) < 7;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
